// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg
//   Shared definitions for the full-speed USB transmit bit engine:
//   the FSM state type, default bit timing and stuffing limit, the SYNC
//   byte and the 2-bit line-state codes packed as {d_plus, d_minus}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam int CLKS_PER_BIT_DEF = 8;
  localparam int STUFF_LIMIT_DEF  = 6;

  // Sent LSB first, this is seven 0s followed by a 1.
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_nrzi.sv
// usb_tx_nrzi
//   Registered NRZI line driver. On each bit strobe the line either
//   toggles (bit 0), holds (bit 1), goes to SE0, or returns to J.
// Ports:
//   clk, rst      system clock, synchronous active-high reset (line -> J)
//   i_bit_strobe  a new bit period starts at this edge
//   i_bit         value of the new bit (ignored for SE0/idle requests)
//   i_se0         new bit period is SE0
//   i_idle        new bit period is J (end of EOP / idle)
//   o_d_plus      bus D+
//   o_d_minus     bus D-
module usb_tx_nrzi
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_bit_strobe,
  input  logic i_bit,
  input  logic i_se0,
  input  logic i_idle,
  output logic o_d_plus,
  output logic o_d_minus
);

  logic [1:0] r_line;

  // Line register. Toggling is a swap of D+/D- because J and K are
  // mirror images of each other; it is only ever requested from J or K.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= LINE_J;
    end else if (i_bit_strobe) begin
      if (i_idle) begin
        r_line <= LINE_J;
      end else if (i_se0) begin
        r_line <= LINE_SE0;
      end else if (!i_bit) begin
        r_line <= {r_line[0], r_line[1]};
      end
    end
  end

  assign o_d_plus  = r_line[1];
  assign o_d_minus = r_line[0];

endmodule

// File: rtl/usb_tx_bit_engine.sv
// usb_tx_bit_engine
//   Full-speed USB transmit bit engine: bit timer, SYNC generation,
//   LSB-first byte serialiser, bit stuffer, NRZI line driver and EOP.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   tx_start       begin a packet (honoured only while idle)
//   tx_data        next byte to send, LSB first
//   tx_data_valid  tx_data holds a byte to send
//   tx_byte_ack    tx_data is consumed at the end of this cycle
//   transmitting   high from the first SYNC bit through the last EOP J cycle
//   d_plus/d_minus bus lines
//   tx_done        one-cycle pulse in the first idle cycle after EOP
module usb_tx_bit_engine
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_byte_ack,
  output logic       transmitting,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);

  tx_state_t     r_state, w_state_nx;
  logic [CW-1:0] r_clk_cnt, w_clk_cnt_nx;
  logic [2:0]    r_bit_idx, w_bit_idx_nx;
  logic [OW-1:0] r_ones_cnt, w_ones_cnt_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_stuff, w_stuff_nx;
  logic          r_load_pending, w_load_pending_nx;
  logic          r_done, w_done_nx;

  logic          w_boundary;
  logic          w_in_bits;
  logic [OW-1:0] w_ones_after;
  logic          w_need_stuff;
  logic          w_load_point;
  logic          w_strobe, w_bit, w_se0, w_idle;

  // r_stuff marks a bit period that is a stuffed 0. A stuff slot after a
  // data bit 0-6 is entered with the shifter already advanced to the next
  // bit, so the shifter simply holds through it. A stuff slot after bit 7
  // sets r_load_pending instead, so the byte load happens when it ends.
  assign w_boundary   = (r_clk_cnt == LAST_CLK);
  assign w_in_bits    = (r_state == ST_SYNC) || (r_state == ST_DATA);
  assign w_ones_after = (r_stuff || !r_shift[0]) ? '0 : r_ones_cnt + OW'(1);
  assign w_need_stuff = !r_stuff && (w_ones_after == ONES_MAX);
  assign w_load_point = w_in_bits && w_boundary &&
                        (r_stuff ? r_load_pending
                                 : ((r_bit_idx == 3'd7) && !w_need_stuff));

  assign tx_byte_ack  = w_load_point && tx_data_valid;
  assign transmitting = (r_state != ST_IDLE);
  assign tx_done      = r_done;

  // Next-state logic. Every bit period begins with a strobe to the NRZI
  // driver carrying the value of the bit that starts on that edge, so the
  // line changes on the same edge as the state/counters.
  always_comb begin
    w_state_nx        = r_state;
    w_clk_cnt_nx      = r_clk_cnt;
    w_bit_idx_nx      = r_bit_idx;
    w_ones_cnt_nx     = r_ones_cnt;
    w_shift_nx        = r_shift;
    w_stuff_nx        = r_stuff;
    w_load_pending_nx = r_load_pending;
    w_done_nx         = 1'b0;
    w_strobe          = 1'b0;
    w_bit             = 1'b1;
    w_se0             = 1'b0;
    w_idle            = 1'b0;

    if (r_state != ST_IDLE) begin
      w_clk_cnt_nx = w_boundary ? '0 : r_clk_cnt + CW'(1);
    end

    unique case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_state_nx        = ST_SYNC;
          w_shift_nx        = SYNC_PATTERN;
          w_bit_idx_nx      = '0;
          w_ones_cnt_nx     = '0;
          w_stuff_nx        = 1'b0;
          w_load_pending_nx = 1'b0;
          w_strobe          = 1'b1;
          w_bit             = SYNC_PATTERN[0];
        end
      end

      ST_SYNC, ST_DATA: begin
        if (w_boundary) begin
          w_ones_cnt_nx = w_ones_after;
          w_strobe      = 1'b1;
          if (w_load_point) begin
            w_stuff_nx        = 1'b0;
            w_load_pending_nx = 1'b0;
            w_bit_idx_nx      = '0;
            if (tx_data_valid) begin
              w_state_nx = ST_DATA;
              w_shift_nx = tx_data;
              w_bit      = tx_data[0];
            end else begin
              w_state_nx = ST_EOP_SE0;
              w_se0      = 1'b1;
            end
          end else if (w_need_stuff) begin
            w_stuff_nx = 1'b1;
            w_bit      = 1'b0;
            if (r_bit_idx == 3'd7) begin
              w_load_pending_nx = 1'b1;
            end else begin
              w_shift_nx   = {1'b0, r_shift[7:1]};
              w_bit_idx_nx = r_bit_idx + 3'd1;
            end
          end else if (r_stuff) begin
            w_stuff_nx = 1'b0;
            w_bit      = r_shift[0];
          end else begin
            w_shift_nx   = {1'b0, r_shift[7:1]};
            w_bit_idx_nx = r_bit_idx + 3'd1;
            w_bit        = r_shift[1];
          end
        end
      end

      ST_EOP_SE0: begin
        if (w_boundary) begin
          if (r_bit_idx == 3'd1) begin
            w_state_nx   = ST_EOP_J;
            w_bit_idx_nx = '0;
            w_strobe     = 1'b1;
            w_idle       = 1'b1;
          end else begin
            w_bit_idx_nx = r_bit_idx + 3'd1;
          end
        end
      end

      ST_EOP_J: begin
        if (w_boundary) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset aborts any packet immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_clk_cnt      <= '0;
      r_bit_idx      <= '0;
      r_ones_cnt     <= '0;
      r_shift        <= '0;
      r_stuff        <= 1'b0;
      r_load_pending <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_clk_cnt      <= w_clk_cnt_nx;
      r_bit_idx      <= w_bit_idx_nx;
      r_ones_cnt     <= w_ones_cnt_nx;
      r_shift        <= w_shift_nx;
      r_stuff        <= w_stuff_nx;
      r_load_pending <= w_load_pending_nx;
      r_done         <= w_done_nx;
    end
  end

  usb_tx_nrzi u_nrzi (
    .clk          (clk),
    .rst          (rst),
    .i_bit_strobe (w_strobe),
    .i_bit        (w_bit),
    .i_se0        (w_se0),
    .i_idle       (w_idle),
    .o_d_plus     (d_plus),
    .o_d_minus    (d_minus)
  );

endmodule

// File: tb/tb_usb_tx_bit_engine.sv
// tb_usb_tx_bit_engine
//   Scoreboard bench for usb_tx_bit_engine. For each packet a reference
//   model builds the expected per-cycle line sequence, ack cycles and
//   packet length from the bus rules; a monitor pops and compares them.
module tb_usb_tx_bit_engine;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_byte_ack;
  logic       transmitting;
  logic       d_plus;
  logic       d_minus;
  logic       tx_done;

  int nChecks = 0;
  int nPass   = 0;

  logic [1:0] expLine[$];
  int         expAck[$];
  int         expLen[$];
  logic [7:0] pktBytes[$];

  logic [1:0] mLvl;
  int         mOnes;
  int         mBits;
  int         pktCyc = 0;

  // 10 ns clock.
  always #5 clk = ~clk;

  usb_tx_bit_engine dut (
    .clk           (clk),
    .rst           (rst),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_byte_ack   (tx_byte_ack),
    .transmitting  (transmitting),
    .d_plus        (d_plus),
    .d_minus       (d_minus),
    .tx_done       (tx_done)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic reportFail(input string name, input string detail);
    nChecks++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // One transmitted bit in the reference model: NRZI level for 8 clocks,
  // then a stuffed 0 whenever six 1s in a row have gone out.
  task automatic emitBit(input logic v);
    if (!v) mLvl = (mLvl == LJ) ? LK : LJ;
    for (int c = 0; c < 8; c++) expLine.push_back(mLvl);
    mBits++;
    if (v) begin
      mOnes++;
      if (mOnes == 6) begin
        mLvl = (mLvl == LJ) ? LK : LJ;
        for (int c = 0; c < 8; c++) expLine.push_back(mLvl);
        mBits++;
        mOnes = 0;
      end
    end else begin
      mOnes = 0;
    end
  endtask

  // Whole-packet expectation: SYNC, each byte LSB first, SE0 x2, J x1.
  task automatic buildModel();
    logic [7:0] b;
    mLvl  = LJ;
    mOnes = 0;
    mBits = 0;
    b = 8'h80;
    for (int i = 0; i < 8; i++) emitBit(b[i]);
    foreach (pktBytes[k]) begin
      expAck.push_back(mBits * 8);
      b = pktBytes[k];
      for (int i = 0; i < 8; i++) emitBit(b[i]);
    end
    for (int c = 0; c < 16; c++) expLine.push_back(LSE0);
    for (int c = 0; c < 8; c++) expLine.push_back(LJ);
    expLen.push_back(mBits * 8 + 24);
  endtask

  // Monitor: every transmitting cycle is compared against the expected
  // line; acks are checked for their cycle within the packet, and tx_done
  // closes the packet. Reset discards whatever was still expected.
  always @(negedge clk) begin
    if (rst) begin
      expLine.delete();
      expAck.delete();
      expLen.delete();
      pktCyc = 0;
    end else begin
      if (transmitting) begin
        pktCyc++;
        if (expLine.size() == 0) reportFail("line_extra", $sformatf("transmitting at cycle %0d, none expected", pktCyc));
        else checkOutput("line", int'({d_plus, d_minus}), int'(expLine.pop_front()));
      end
      if (tx_byte_ack) begin
        if (expAck.size() == 0) reportFail("ack_unexpected", $sformatf("ack at cycle %0d", pktCyc));
        else checkOutput("ack_cycle", pktCyc, expAck.pop_front());
      end
      if (tx_done) begin
        if (expLen.size() == 0) begin
          reportFail("done_unexpected", "tx_done pulsed with no packet pending");
        end else begin
          checkOutput("pkt_len", pktCyc, expLen.pop_front());
          checkOutput("acks_left", expAck.size(), 0);
          checkOutput("line_left", expLine.size(), 0);
          checkOutput("idle_line", int'({d_plus, d_minus}), int'(LJ));
        end
        pktCyc = 0;
      end
    end
  end

  // Sends pktBytes as one packet, feeding the next byte after each ack and
  // optionally re-pulsing tx_start mid-packet, then waits for tx_done.
  task automatic applyStimulus(input logic repulse);
    int   k;
    int   cyc;
    logic ackSeen;
    logic doneSeen;
    buildModel();
    k = 0;
    tx_data_valid = (pktBytes.size() > 0);
    tx_data = (pktBytes.size() > 0) ? pktBytes[0] : 8'h00;
    @(posedge clk); #1 tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    cyc = 0;
    doneSeen = 1'b0;
    while (!doneSeen && cyc < 3000) begin
      @(negedge clk);
      ackSeen  = tx_byte_ack;
      doneSeen = tx_done;
      @(posedge clk); #1;
      cyc++;
      if (repulse) tx_start = (cyc == 100);
      if (ackSeen) begin
        k++;
        if (k < pktBytes.size()) tx_data = pktBytes[k];
        else begin
          tx_data_valid = 1'b0;
          tx_data = 8'($urandom);
        end
      end
    end
    tx_start = 1'b0;
    tx_data_valid = 1'b0;
    if (!doneSeen) reportFail("timeout", "tx_done not seen within 3000 cycles");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int doneCnt;
    int r;
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data_valid = 1'b1;
    tx_data = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dplus", int'(d_plus), 1);
    checkOutput("rst_dminus", int'(d_minus), 0);
    checkOutput("rst_transmitting", int'(transmitting), 0);
    checkOutput("rst_done", int'(tx_done), 0);
    checkOutput("rst_ack", int'(tx_byte_ack), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    pktBytes = '{8'h00};
    applyStimulus(1'b0);
    pktBytes = '{8'hFF};
    applyStimulus(1'b0);
    pktBytes = '{8'hA5, 8'h3C};
    applyStimulus(1'b0);
    pktBytes.delete();
    applyStimulus(1'b0);
    pktBytes = '{8'hFF, 8'h7E};
    applyStimulus(1'b1);

    // Abort mid-packet: two reset cycles, then the line must be idle J
    // and tx_done must never appear.
    pktBytes = '{8'hFF, 8'h12};
    buildModel();
    tx_data = 8'hFF;
    tx_data_valid = 1'b1;
    @(posedge clk); #1 tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (90) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_dplus", int'(d_plus), 1);
    checkOutput("abort_dminus", int'(d_minus), 0);
    checkOutput("abort_transmitting", int'(transmitting), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_data_valid = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done) doneCnt++;
    end
    checkOutput("abort_no_done", doneCnt, 0);
    checkOutput("abort_idle_line", int'({d_plus, d_minus}), int'(LJ));
    @(posedge clk); #1;

    for (int p = 0; p < 8; p++) begin
      pktBytes.delete();
      r = $urandom_range(0, 3);
      for (int i = 0; i < r; i++) begin
        case ($urandom_range(0, 3))
          0:       pktBytes.push_back(8'hFF);
          1:       pktBytes.push_back(8'h7E);
          default: pktBytes.push_back(8'($urandom));
        endcase
      end
      applyStimulus(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/usb_tx_bit_engine.md
Name: usb_tx_bit_engine

Overview:
- Full-speed USB transmit bit engine; the transmit-side counterpart of the RX timer/bit-recovery path.
- Generates bit timing of 8 clocks per bit, auto-prepends SYNC, serialises bytes LSB-first, inserts stuff bits, NRZI-encodes onto d_plus/d_minus, and appends EOP.
- Sits between the TX packet/CRC layer (byte source) and the bus pads.

Parameters:
CLKS_PER_BIT, 8, clocks per USB bit time (12 Mb/s at 96 MHz-equivalent, 80 ns bit at 10 ns clk)
STUFF_LIMIT, 6, consecutive transmitted 1s that force a stuffed 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
tx_start  in  1  pulse; begin packet (sampled only in IDLE)
tx_data  in  8  next byte to send, LSB first
tx_data_valid  in  1  tx_data holds a byte to send
tx_byte_ack  out  1  high in the cycle tx_data is sampled; valid&ack on a clk edge = byte consumed
transmitting  out  1  high from first SYNC bit through last EOP J cycle
d_plus  out  1  bus D+
d_minus  out  1  bus D-
tx_done  out  1  one-cycle pulse after EOP completes

Behaviour:
- Reset: state IDLE, d_plus=1, d_minus=0 (J), transmitting=0, tx_done=0, tx_byte_ack=0; clk_cnt, bit_idx, ones_cnt cleared. rst mid-packet aborts on the next edge: line J, no tx_done, no ack.
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- IDLE: tx_start high at edge N -> SYNC; first SYNC bit on line at N+1, transmitting=1. tx_start is ignored in all other states.
- Timer: clk_cnt 0..CLKS_PER_BIT-1 and wraps. Bit boundary = clk_cnt==CLKS_PER_BIT-1. Each bit (data, sync, or stuff) is held exactly CLKS_PER_BIT cycles.
- SYNC: serialises 8'h80 LSB-first (0000_0001), giving the line sequence KJKJKJKK.
- NRZI: bit 0 toggles the line (J<->K); bit 1 holds it. J=(1,0), K=(0,1).
- Stuffing:
  - ones_cnt counts consecutive transmitted 1s, including SYNC's final 1.
  - ones_cnt resets on any 0 or stuffed bit.
  - When ones_cnt reaches STUFF_LIMIT at a bit boundary, the next bit period is a stuff 0 (toggle). bit_idx does not advance and the shift register holds.
  - Stuffing applies after a byte's final bit, before the next byte or before EOP.
- Byte load:
  - Occurs at the bit boundary ending bit 7 of SYNC/DATA, or at the end of a pending stuff bit if one follows bit 7.
  - If tx_data_valid: tx_byte_ack=1 that cycle, tx_data is latched, and the next bit period starts DATA bit 0 with no gap.
  - tx_byte_ack is a combinational decode of registered state/counters AND tx_data_valid; it is never high otherwise.
- No valid at load point: -> EOP_SE0. A zero-length packet (no valid after SYNC) is legal.
- EOP: SE0 (0,0) for 2 bit times (16 clk), then J for 1 bit time (8 clk), then IDLE.
- Completion: transmitting=0 and tx_done=1 in the first IDLE cycle.
- Priority: rst > everything. tx_data_valid is sampled only at load points.

Decomposition:
- usb_tx_pkg contains:
  - state enum
  - CLKS_PER_BIT/STUFF_LIMIT defaults
  - SYNC_PATTERN = 8'h80
  - line-state constants J/K/SE0 (2-bit {d_plus,d_minus})
- Sub-module usb_tx_nrzi:
  - inputs: bit strobe, bit value, se0 request, idle request
  - registered d_plus/d_minus; reset to J
- Timer, stuffer and FSM stay in the top module.

Test Plan:
1. Reset: rst high 2 cycles during an active packet -> next cycle d_plus=1, d_minus=0, transmitting=0, tx_done never pulses.
2. tx_start at N, one byte 8'h00 then valid low -> KJKJKJKK (8 clk each) over N+1..N+64, ack only at N+64, 8 toggling bits over N+65..N+128, SE0 over N+129..N+144, J over N+145..N+152, tx_done=1 at N+153.
3. Single byte 8'hFF -> line static 48 clocks (SYNC bit 7 + data bits 0-4), a stuff toggle, then 3 held bits. The byte occupies 72 clocks; EOP starts at N+137.
4. Back-to-back 8'hA5, 8'h3C with valid held -> two acks exactly 64 clocks apart, no idle bit between bytes, correct NRZI sequence, single EOP.
5. Zero-length: tx_start with tx_data_valid=0 -> SYNC, then SE0 at N+65, tx_done at N+89, no ack ever.
6. tx_start re-pulsed mid-DATA -> ignored (bit sequence unchanged). Stuff check: byte 8'h7E after a preceding 8'hFF, stuff bit positions match the ones_cnt rule.
